// File: rtl/sram_bist_ctrl.sv
// March C- BIST controller for an OpenRAM 1RW macro. It passes the functional
// pins through while idle and owns the macro port while a test runs.
module sram_bist_ctrl #(
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 32,
    parameter int MASK_WIDTH     = 4,
    parameter int READ_LATENCY   = 1,
    parameter int FAIL_CNT_WIDTH = 8
) (
    input  logic                      clk0,
    input  logic                      rstb0,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      fail,
    output logic [ADDR_WIDTH-1:0]     fail_addr,
    output logic [FAIL_CNT_WIDTH-1:0] fail_count,
    input  logic                      func_csb0,
    input  logic                      func_web0,
    input  logic [MASK_WIDTH-1:0]     func_wmask0,
    input  logic [ADDR_WIDTH-1:0]     func_addr0,
    input  logic [DATA_WIDTH-1:0]     func_din0,
    output logic [DATA_WIDTH-1:0]     func_dout0,
    output logic                      csb0,
    output logic                      web0,
    output logic [MASK_WIDTH-1:0]     wmask0,
    output logic [ADDR_WIDTH-1:0]     addr0,
    output logic [DATA_WIDTH-1:0]     din0,
    input  logic [DATA_WIDTH-1:0]     dout0
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0]     ADDR_MAX   = '1;
    localparam logic [ADDR_WIDTH-1:0]     ADDR_ONE   = 1;
    localparam logic [FAIL_CNT_WIDTH-1:0] CNT_ONE    = 1;
    localparam logic [1:0]                DRAIN_LAST = 2'(READ_LATENCY - 1);

    state_t                  state, state_nxt;
    logic [2:0]              elem;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    phase;
    logic [1:0]              drain_cnt;

    logic                    start_ok;
    logic                    desc, two_op, op_write, op_pat, op_done, addr_term, last_op;

    logic [READ_LATENCY-1:0] pipe_vld;
    logic [READ_LATENCY-1:0] pipe_exp;
    logic [ADDR_WIDTH-1:0]   pipe_addr [READ_LATENCY];
    logic                    miscompare;

    // Decode the current march op; patterns are all-zeros/all-ones so one bit suffices.
    assign start_ok  = start && (state == S_IDLE || state == S_DONE);
    assign desc      = (elem == 3'd3) || (elem == 3'd4);
    assign two_op    = (elem != 3'd0) && (elem != 3'd5);
    assign op_write  = (elem == 3'd0) || (two_op && phase);
    assign op_pat    = op_write ? ((elem == 3'd1) || (elem == 3'd3))
                                : ((elem == 3'd2) || (elem == 3'd4));
    assign op_done   = !two_op || phase;
    assign addr_term = desc ? (addr == '0) : (addr == ADDR_MAX);
    assign last_op   = (elem == 3'd5) && (addr == ADDR_MAX);

    assign busy       = (state == S_RUN) || (state == S_DRAIN);
    assign done       = (state == S_DONE);
    assign func_dout0 = dout0;

    always_ff @(posedge clk0) begin
        if (!rstb0) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        csb0      = func_csb0;
        web0      = func_web0;
        wmask0    = func_wmask0;
        addr0     = func_addr0;
        din0      = func_din0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                csb0   = 1'b0;
                web0   = !op_write;
                wmask0 = '1;
                addr0  = addr;
                din0   = op_write ? {DATA_WIDTH{op_pat}} : '0;
                if (last_op) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                csb0   = 1'b1;
                web0   = 1'b1;
                wmask0 = '0;
                addr0  = '0;
                din0   = '0;
                if (drain_cnt == DRAIN_LAST) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk0) begin
        if (!rstb0) begin
            elem      <= '0;
            addr      <= '0;
            phase     <= 1'b0;
            drain_cnt <= '0;
        end else if (start_ok) begin
            elem      <= '0;
            addr      <= '0;
            phase     <= 1'b0;
            drain_cnt <= '0;
        end else if (state == S_RUN) begin
            if (!op_done) begin
                phase <= 1'b1;
            end else begin
                phase <= 1'b0;
                if (addr_term) begin
                    elem <= elem + 3'd1;
                    // E3/E4 are the descending elements, so they start from the top.
                    addr <= (elem == 3'd2 || elem == 3'd3) ? ADDR_MAX : '0;
                end else begin
                    addr <= desc ? addr - ADDR_ONE : addr + ADDR_ONE;
                end
            end
        end else if (state == S_DRAIN) begin
            drain_cnt <= drain_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk0) begin
        if (!rstb0) begin
            pipe_vld <= '0;
            pipe_exp <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) pipe_addr[i] <= '0;
        end else begin
            pipe_vld[0]  <= (state == S_RUN) && !op_write;
            pipe_exp[0]  <= op_pat;
            pipe_addr[0] <= addr;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_exp[i]  <= pipe_exp[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end
        end
    end

    assign miscompare = pipe_vld[READ_LATENCY-1] &&
                        (dout0 != {DATA_WIDTH{pipe_exp[READ_LATENCY-1]}});

    always_ff @(posedge clk0) begin
        if (!rstb0 || start_ok) begin
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_count <= '0;
        end else if (miscompare) begin
            fail <= 1'b1;
            if (!fail) fail_addr <= pipe_addr[READ_LATENCY-1];
            if (fail_count != '1) fail_count <= fail_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Directed bench: two controllers (read latency 1 and 3) on behavioural macros,
// with stuck-at and address-alias faults injectable on the latency-1 macro.
module tb_sram_bist_ctrl;

    logic        clk0 = 1'b0;
    logic        rstb0, start;
    logic        func_csb0, func_web0;
    logic [3:0]  func_wmask0;
    logic [5:0]  func_addr0;
    logic [31:0] func_din0;

    logic        d1_busy, d1_done, d1_fail, d1_csb0, d1_web0;
    logic [5:0]  d1_fail_addr, d1_addr0;
    logic [7:0]  d1_fail_count;
    logic [3:0]  d1_wmask0;
    logic [31:0] d1_din0, d1_dout0, d1_func_dout0;

    logic        d3_busy, d3_done, d3_fail, d3_csb0, d3_web0;
    logic [5:0]  d3_fail_addr, d3_addr0;
    logic [7:0]  d3_fail_count;
    logic [3:0]  d3_wmask0;
    logic [31:0] d3_din0, d3_dout0, d3_func_dout0;

    logic [31:0] mem1 [64];
    logic [31:0] mem3 [64];
    logic [31:0] r3_0, r3_1;
    int          fault_mode;  // 0 none, 1 stuck-at-1 bit 5 @17, 2 addr 40 aliases 41
    int          npass = 0, ntot = 0;

    always #5 clk0 = ~clk0;

    sram_bist_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .MASK_WIDTH(4),
                     .READ_LATENCY(1), .FAIL_CNT_WIDTH(8)) dut1 (
        .clk0(clk0), .rstb0(rstb0), .start(start), .busy(d1_busy), .done(d1_done),
        .fail(d1_fail), .fail_addr(d1_fail_addr), .fail_count(d1_fail_count),
        .func_csb0(func_csb0), .func_web0(func_web0), .func_wmask0(func_wmask0),
        .func_addr0(func_addr0), .func_din0(func_din0), .func_dout0(d1_func_dout0),
        .csb0(d1_csb0), .web0(d1_web0), .wmask0(d1_wmask0), .addr0(d1_addr0),
        .din0(d1_din0), .dout0(d1_dout0));

    sram_bist_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .MASK_WIDTH(4),
                     .READ_LATENCY(3), .FAIL_CNT_WIDTH(8)) dut3 (
        .clk0(clk0), .rstb0(rstb0), .start(start), .busy(d3_busy), .done(d3_done),
        .fail(d3_fail), .fail_addr(d3_fail_addr), .fail_count(d3_fail_count),
        .func_csb0(func_csb0), .func_web0(func_web0), .func_wmask0(func_wmask0),
        .func_addr0(func_addr0), .func_din0(func_din0), .func_dout0(d3_func_dout0),
        .csb0(d3_csb0), .web0(d3_web0), .wmask0(d3_wmask0), .addr0(d3_addr0),
        .din0(d3_din0), .dout0(d3_dout0));

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [5:0] phys(input logic [5:0] a);
        return (fault_mode == 2 && a == 6'd40) ? 6'd41 : a;
    endfunction

    always @(posedge clk0) begin
        if (!d1_csb0) begin
            if (!d1_web0)
                mem1[phys(d1_addr0)] <= merge(mem1[phys(d1_addr0)], d1_din0, d1_wmask0);
            else
                d1_dout0 <= mem1[phys(d1_addr0)] |
                            ((fault_mode == 1 && d1_addr0 == 6'd17) ? 32'h20 : 32'h0);
        end
    end

    always @(posedge clk0) begin
        if (!d3_csb0) begin
            if (!d3_web0) mem3[d3_addr0] <= merge(mem3[d3_addr0], d3_din0, d3_wmask0);
            else          r3_0 <= mem3[d3_addr0];
        end
        r3_1     <= r3_0;
        d3_dout0 <= r3_1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntot++;
        assert (got === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // Pulses start, then counts busy cycles of both controllers (bounded).
    task automatic run_test(input int repulse_at, output int n1, output int n3,
                            output logic first_fail, output logic [7:0] first_cnt,
                            output logic drain_csb);
        @(negedge clk0) start = 1'b1;
        @(negedge clk0) start = 1'b0;
        first_fail = d1_fail;
        first_cnt  = d1_fail_count;
        drain_csb  = 1'b0;
        n1 = 0;
        n3 = 0;
        for (int k = 0; k < 2000 && (d1_busy || d3_busy); k++) begin
            if (d1_busy) begin n1++; drain_csb = d1_csb0; end
            if (d3_busy) n3++;
            start = (k == repulse_at);
            @(negedge clk0);
        end
        start = 1'b0;
    endtask

    int          n1, n3;
    logic        ff, dcsb;
    logic [7:0]  fc;

    initial begin
        fault_mode  = 0;
        rstb0       = 1'b0;
        start       = 1'b0;
        func_csb0   = 1'b1;
        func_web0   = 1'b1;
        func_wmask0 = 4'h0;
        func_addr0  = 6'd9;
        func_din0   = 32'h1234_5678;
        repeat (3) @(negedge clk0);
        chk("rst_busy", d1_busy, 0);
        chk("rst_done", d1_done, 0);
        chk("rst_fail", d1_fail, 0);
        chk("rst_fail_addr", d1_fail_addr, 0);
        chk("rst_fail_count", d1_fail_count, 0);
        chk("rst_pass_csb", d1_csb0, 1);
        chk("rst_pass_addr", d1_addr0, 9);
        chk("rst_pass_din", d1_din0, 32'h1234_5678);
        rstb0 = 1'b1;

        run_test(-1, n1, n3, ff, fc, dcsb);
        chk("clean_busy_len_L1", n1, 641);
        chk("clean_busy_len_L3", n3, 643);
        chk("clean_drain_csb", dcsb, 1);
        chk("clean_done", d1_done, 1);
        chk("clean_fail", d1_fail, 0);
        chk("clean_fail_count", d1_fail_count, 0);
        chk("clean_done_L3", d3_done, 1);
        chk("clean_fail_L3", d3_fail, 0);

        fault_mode = 2;
        run_test(-1, n1, n3, ff, fc, dcsb);
        chk("alias_busy_len", n1, 641);
        chk("alias_fail", d1_fail, 1);
        chk("alias_fail_addr", d1_fail_addr, 41);
        chk("alias_fail_count", d1_fail_count, 4);

        fault_mode = 1;
        run_test(-1, n1, n3, ff, fc, dcsb);
        chk("stuck_entry_fail_clr", ff, 0);
        chk("stuck_entry_cnt_clr", fc, 0);
        chk("stuck_fail", d1_fail, 1);
        chk("stuck_fail_addr", d1_fail_addr, 17);
        chk("stuck_fail_count", d1_fail_count, 3);
        chk("stuck_done", d1_done, 1);

        @(negedge clk0);
        func_csb0   = 1'b0;
        func_web0   = 1'b0;
        func_wmask0 = 4'b0101;
        func_addr0  = 6'd3;
        func_din0   = 32'hDEAD_BEEF;
        #1;
        chk("pt_csb", d1_csb0, 0);
        chk("pt_web", d1_web0, 0);
        chk("pt_wmask", d1_wmask0, 4'b0101);
        chk("pt_addr", d1_addr0, 3);
        chk("pt_din", d1_din0, 32'hDEAD_BEEF);
        @(negedge clk0);
        func_web0 = 1'b1;
        func_din0 = 32'h0;
        #1;
        chk("pt_web_read", d1_web0, 1);
        @(negedge clk0);
        func_csb0 = 1'b1;
        chk("pt_read_data", d1_func_dout0, 32'h00AD_00EF);
        chk("pt_read_data_L3_pending_done", d3_done, 1);

        fault_mode = 0;
        run_test(5, n1, n3, ff, fc, dcsb);
        chk("restart_busy_len_L1", n1, 641);
        chk("restart_busy_len_L3", n3, 643);
        chk("restart_fail_count", d1_fail_count, 0);
        chk("restart_fail", d1_fail, 0);
        chk("restart_done", d1_done, 1);

        @(negedge clk0) start = 1'b1;
        @(negedge clk0) start = 1'b0;
        repeat (299) @(negedge clk0);
        chk("midrst_busy_before", d1_busy, 1);
        rstb0      = 1'b0;
        func_csb0  = 1'b0;
        func_web0  = 1'b1;
        func_addr0 = 6'd5;
        @(negedge clk0);
        chk("midrst_busy", d1_busy, 0);
        chk("midrst_done", d1_done, 0);
        chk("midrst_fail_count", d1_fail_count, 0);
        chk("midrst_csb", d1_csb0, 0);
        chk("midrst_addr", d1_addr0, 5);
        rstb0     = 1'b1;
        func_csb0 = 1'b1;
        @(negedge clk0);
        chk("midrst_stays_idle", d1_busy, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/sram_bist_ctrl.md
Name: sram_bist_ctrl

Overview:
- March C- built-in self-test controller that drives the OpenRAM single-port (1RW) macro pins: clk0, csb0, web0, wmask0, addr0, din0, dout0.
- It is the initiator for the same macro interface that the data array wrappers respond on.
- It sits between the functional wrapper logic and the macro. It muxes the functional pins through while idle, and owns the port while a test runs.
- It reports pass/fail, the first failing address and a saturating failure count.

Parameters:
- ADDR_WIDTH, 6, macro address width; depth N = 2^ADDR_WIDTH.
- DATA_WIDTH, 32, macro data width.
- MASK_WIDTH, 4, macro write-mask width; each bit covers DATA_WIDTH/MASK_WIDTH bits.
- READ_LATENCY, 1, clk0 edges from the read-issue edge to dout0 valid; legal range 1..3.
- FAIL_CNT_WIDTH, 8, width of fail_count.

Ports:
- clk0  in  1  single clock, shared with the macro.
- rstb0  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a test from IDLE or DONE.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE; held until the next start or reset.
- fail  out  1  sticky; set on any miscompare in the current test.
- fail_addr  out  ADDR_WIDTH  address of the first miscompare.
- fail_count  out  FAIL_CNT_WIDTH  miscompares in the current test; saturates at all-ones.
- func_csb0  in  1  functional chip select, active low.
- func_web0  in  1  functional write enable, active low.
- func_wmask0  in  MASK_WIDTH  functional write mask.
- func_addr0  in  ADDR_WIDTH  functional address.
- func_din0  in  DATA_WIDTH  functional write data.
- func_dout0  out  DATA_WIDTH  equals dout0 at all times.
- csb0  out  1  macro chip select, active low.
- web0  out  1  macro write enable, active low.
- wmask0  out  MASK_WIDTH  macro write mask.
- addr0  out  ADDR_WIDTH  macro address.
- din0  out  DATA_WIDTH  macro write data.
- dout0  in  DATA_WIDTH  macro read data.

Behaviour:
- Reset (rstb0 low at a clk0 edge):
  - state = IDLE.
  - busy, done, fail = 0; fail_addr = 0; fail_count = 0.
  - Element, address and phase counters cleared; read-compare pipeline cleared.
- States and transitions:
  - IDLE --start--> RUN.
  - RUN --last op issued--> DRAIN.
  - DRAIN --READ_LATENCY edges--> DONE.
  - DONE --start--> RUN.
  - start in RUN or DRAIN is ignored.
- Entering RUN clears fail, fail_addr, fail_count and done.
- Pin ownership:
  - In IDLE and DONE, the macro pins combinationally equal the func_* inputs.
  - In RUN, the controller drives the pins: csb0 = 0, wmask0 = all ones.
  - In DRAIN, csb0 = 1 and web0 = 1.
- Reset mid-operation: the next cycle is IDLE with pass-through active. No partial result is retained.
- March sequence, one op per clk0 cycle with no bubbles. D0 = all zeros, D1 = all ones.
  - E0 ascending: w D0.
  - E1 ascending: r D0, w D1.
  - E2 ascending: r D1, w D0.
  - E3 descending: r D0, w D1.
  - E4 descending: r D1, w D0.
  - E5 ascending: r D0.
- Two-op elements issue read then write at the same address before the address advances.
- Address counting:
  - Ascending runs 0..N-1; descending runs N-1..0.
  - The element index advances when the terminal address completes.
- RUN lasts exactly 10*N cycles; busy is high for 10*N + READ_LATENCY cycles.
- Write op: web0 = 0, din0 = pattern. Read op: web0 = 1, din0 = 0.
- Read checking:
  - Each issued read pushes {valid, addr, expected} into a READ_LATENCY-deep shift pipeline.
  - At the pipeline output, dout0 is compared with expected.
  - On mismatch: fail = 1; fail_count += 1, saturating.
  - fail_addr is loaded only if fail was 0 before that compare.
  - Compares from the last reads complete during DRAIN.
- done and the fail outputs are registered; they update on the edge that completes the final compare.

Test Plan:
- Fault-free behavioural macro (N=64, DATA=32, L=1), start pulse → busy high for 641 cycles; done = 1; fail = 0; fail_count = 0.
- Macro with bit 5 of address 17 stuck-at-1 → fail = 1; fail_addr = 17; fail_count = 3 (E1, E3 and E5 reads).
- Macro with address 40 aliased onto address 41 → fail = 1; fail_addr = 40 or 41 as the first compare dictates; fail_count ≥ 1; the bench checks against a reference model.
- Pulse start again 5 cycles into RUN → ignored; total busy length unchanged. rstb0 low at cycle 300 → next cycle IDLE; busy = 0; csb0 equals func_csb0.
- IDLE/DONE pass-through: func write 0xDEADBEEF to address 3 with func_wmask0 = 4'b0101, then func read → macro pins mirror the func inputs; func_dout0 shows the masked bytes. A second start from DONE reruns the test and clears fail_count.
- With READ_LATENCY = 3 and the fault-free macro → busy lasts 643 cycles; fail = 0.
